// File: rtl/solution_unpacker.sv
// solution_unpacker: rebuilds an m x n solution bitmap from the UART byte stream.
// Frame = header {m[7:4], n[3:0]} followed by ceil(m*n/8) payload bytes, LSB-first.
// Optional feature: define UNPACK_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES
// idle cycles in PAYLOAD.
module solution_unpacker #(
  parameter int unsigned MAX_ROWS       = 11,
  parameter int unsigned MAX_COLS       = 11,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                           clk_100mhz,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic [7:0]                     byte_in,
  output logic [$clog2(MAX_ROWS)-1:0]    m_out,
  output logic [$clog2(MAX_COLS)-1:0]    n_out,
  output logic [MAX_ROWS*MAX_COLS-1:0]   solution,
  output logic                           valid_out,
  output logic                           busy,
  output logic                           error
);

  localparam int unsigned Cells = MAX_ROWS * MAX_COLS;
  localparam int unsigned MW    = $clog2(MAX_ROWS);
  localparam int unsigned NW    = $clog2(MAX_COLS);
  localparam int unsigned TW    = $clog2(Cells + 8);

  typedef enum logic [0:0] {StHeader, StPayload} state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    m_q, m_d;
  logic [NW-1:0]    n_q, n_d;
  logic [TW-1:0]    total_q, total_d;
  logic [TW-1:0]    pbytes_q, pbytes_d;
  logic [TW-1:0]    bit_idx_q, bit_idx_d;
  logic [TW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [Cells-1:0] shadow_q, shadow_d;
  logic [Cells-1:0] solution_q, solution_d;
  logic [MW-1:0]    m_out_q, m_out_d;
  logic [NW-1:0]    n_out_q, n_out_d;
  logic             valid_out_q, valid_out_d;
  logic             error_q, error_d;
  logic [3:0]       hdr_m, hdr_n;
  int unsigned      hdr_cells;
  int unsigned      idx;

`ifdef UNPACK_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign hdr_m     = byte_in[7:4];
  assign hdr_n     = byte_in[3:0];
  assign hdr_cells = 32'(hdr_m) * 32'(hdr_n);

  // Next-state logic: header decode, payload bit scatter and frame completion.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    total_d     = total_q;
    pbytes_d    = pbytes_q;
    bit_idx_d   = bit_idx_q;
    byte_cnt_d  = byte_cnt_q;
    shadow_d    = shadow_q;
    solution_d  = solution_q;
    m_out_d     = m_out_q;
    n_out_d     = n_out_q;
    valid_out_d = 1'b0;
    error_d     = 1'b0;
    idx         = 0;
`ifdef UNPACK_TIMEOUT_EN
    idle_d      = '0;
`endif
    unique case (state_q)
      StHeader: begin
        if (valid_in) begin
          if (hdr_m >= 4'd1 && 32'(hdr_m) <= MAX_ROWS &&
              hdr_n >= 4'd1 && 32'(hdr_n) <= MAX_COLS) begin
            m_d        = MW'(hdr_m);
            n_d        = NW'(hdr_n);
            total_d    = TW'(hdr_cells);
            pbytes_d   = TW'((hdr_cells + 7) >> 3);
            shadow_d   = '0;
            bit_idx_d  = '0;
            byte_cnt_d = '0;
            state_d    = StPayload;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StPayload: begin
        if (valid_in) begin
          // Bits landing at or past total are dropped so unused cells stay 0.
          for (int j = 0; j < 8; j++) begin
            idx = 32'(bit_idx_q) + 32'(j);
            if (idx < 32'(total_q)) shadow_d[idx] = byte_in[j];
          end
          bit_idx_d  = bit_idx_q + TW'(8);
          byte_cnt_d = byte_cnt_q + TW'(1);
          if (byte_cnt_q + TW'(1) == pbytes_q) begin
            solution_d  = shadow_d;
            m_out_d     = m_q;
            n_out_d     = n_q;
            valid_out_d = 1'b1;
            state_d     = StHeader;
          end
        end
`ifdef UNPACK_TIMEOUT_EN
        else if (32'(idle_q) == TIMEOUT_CYCLES - 1) begin
          error_d = 1'b1;
          state_d = StHeader;
        end else begin
          idle_d = idle_q + IW'(1);
        end
`endif
      end
      default: state_d = StHeader;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q     <= StHeader;
      m_q         <= '0;
      n_q         <= '0;
      total_q     <= '0;
      pbytes_q    <= '0;
      bit_idx_q   <= '0;
      byte_cnt_q  <= '0;
      shadow_q    <= '0;
      solution_q  <= '0;
      m_out_q     <= '0;
      n_out_q     <= '0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
`ifdef UNPACK_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      total_q     <= total_d;
      pbytes_q    <= pbytes_d;
      bit_idx_q   <= bit_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      shadow_q    <= shadow_d;
      solution_q  <= solution_d;
      m_out_q     <= m_out_d;
      n_out_q     <= n_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
`ifdef UNPACK_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign m_out     = m_out_q;
  assign n_out     = n_out_q;
  assign solution  = solution_q;
  assign valid_out = valid_out_q;
  assign error     = error_q;
  assign busy      = (state_q == StPayload);

endmodule

// File: tb/tb_solution_unpacker.sv
// Directed, table-driven bench for solution_unpacker (11x11 default geometry).
module tb_solution_unpacker;

`ifdef UNPACK_TIMEOUT_EN
  localparam int unsigned TO = 100;
`else
  localparam int unsigned TO = 1_000_000;
`endif

  logic         clk_100mhz = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  logic [7:0]   byte_in = 8'h00;
  logic [3:0]   m_out, n_out;
  logic [120:0] solution;
  logic         valid_out, busy, error;

  always #5 clk_100mhz = ~clk_100mhz;

  solution_unpacker #(
    .MAX_ROWS      (11),
    .MAX_COLS      (11),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .valid_in  (valid_in),
    .byte_in   (byte_in),
    .m_out     (m_out),
    .n_out     (n_out),
    .solution  (solution),
    .valid_out (valid_out),
    .busy      (busy),
    .error     (error)
  );

  typedef struct {
    logic         r;
    logic         v;
    logic [7:0]   b;
    logic         vo;
    logic         er;
    logic         bz;
    logic         cs;
    logic [3:0]   m;
    logic [3:0]   n;
    logic [120:0] s;
  } vec_t;

  vec_t tbl[$];
  int   n_applied = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic v, input logic [7:0] b, input logic vo,
                     input logic er, input logic bz, input logic cs, input logic [3:0] m,
                     input logic [3:0] n, input logic [120:0] s);
    vec_t x;
    x.r = r; x.v = v; x.b = b; x.vo = vo; x.er = er; x.bz = bz;
    x.cs = cs; x.m = m; x.n = n; x.s = s;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic v, input logic [7:0] b);
    @(negedge clk_100mhz);
    rst = r; valid_in = v; byte_in = b;
    @(posedge clk_100mhz);
    #1;
  endtask

  initial begin
    int  cyc;
    bit  seen;
    // Reset state
    add(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, '0);
    // 3x2 frame: 0xE5 -> bits[5:0] = 100101
    add(0, 1, 8'h32, 0, 0, 1, 1, 0, 0, '0);
    add(0, 1, 8'hE5, 1, 0, 0, 1, 3, 2, 121'h25);
    add(0, 0, 8'h00, 0, 0, 0, 1, 3, 2, 121'h25);
    // Rejected headers: m=12, then n=0; outputs held
    add(0, 1, 8'hC5, 0, 1, 0, 1, 3, 2, 121'h25);
    add(0, 1, 8'h50, 0, 1, 0, 1, 3, 2, 121'h25);
    add(0, 0, 8'h00, 0, 0, 0, 1, 3, 2, 121'h25);
    // 3x4 with an idle gap mid-payload; top nibble of last byte discarded
    add(0, 1, 8'h34, 0, 0, 1, 0, 0, 0, '0);
    add(0, 1, 8'h5A, 0, 0, 1, 1, 3, 2, 121'h25);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, '0);
    add(0, 1, 8'hF3, 1, 0, 0, 1, 3, 4, 121'h35A);
    // 11x11 full frame
    add(0, 1, 8'hBB, 0, 0, 1, 1, 3, 4, 121'h35A);
    for (int i = 0; i < 15; i++) add(0, 1, 8'hFF, 0, 0, 1, 0, 0, 0, '0);
    add(0, 1, 8'h01, 1, 0, 0, 1, 11, 11, '1);
    // Back-to-back: header in the valid_out cycle; shadow must be cleared
    add(0, 1, 8'h23, 0, 0, 1, 1, 11, 11, '1);
    add(0, 1, 8'hFF, 1, 0, 0, 1, 2, 3, 121'h3F);
    add(0, 1, 8'h32, 0, 0, 1, 1, 2, 3, 121'h3F);
    add(0, 1, 8'hE5, 1, 0, 0, 1, 3, 2, 121'h25);
    // Reset mid-frame, then a clean 3x2 frame
    add(0, 1, 8'hBB, 0, 0, 1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) add(0, 1, 8'hAA, 0, 0, 1, 0, 0, 0, '0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, '0);
    add(0, 1, 8'h32, 0, 0, 1, 1, 0, 0, '0);
    add(0, 1, 8'hE5, 1, 0, 0, 1, 3, 2, 121'h25);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].b);
      chk($sformatf("v%0d.valid_out", i), 128'(valid_out), 128'(tbl[i].vo));
      chk($sformatf("v%0d.error", i), 128'(error), 128'(tbl[i].er));
      chk($sformatf("v%0d.busy", i), 128'(busy), 128'(tbl[i].bz));
      if (tbl[i].cs) begin
        chk($sformatf("v%0d.m_out", i), 128'(m_out), 128'(tbl[i].m));
        chk($sformatf("v%0d.n_out", i), 128'(n_out), 128'(tbl[i].n));
        chk($sformatf("v%0d.solution", i), 128'(solution), 128'(tbl[i].s));
      end
    end

    // valid_out is a single-cycle pulse; outputs hold afterwards
    step(0, 0, 8'h00);
    chk("pulse.valid_out_low", 128'(valid_out), 128'(0));
    chk("pulse.solution_held", 128'(solution), 128'h25);

`ifdef UNPACK_TIMEOUT_EN
    // Header with no payload: error 100 cycles after the header edge
    step(0, 1, 8'h22);
    chk("timeout.busy_after_hdr", 128'(busy), 128'(1));
    cyc = 0;
    seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      step(0, 0, 8'h00);
      if (error) begin
        seen = 1'b1;
        cyc = c;
      end
    end
    chk("timeout.cycles", 128'(cyc), 128'(100));
    chk("timeout.busy_fell", 128'(busy), 128'(0));
    chk("timeout.valid_out", 128'(valid_out), 128'(0));
    chk("timeout.sol_held", 128'(solution), 128'h25);
    chk("timeout.m_held", 128'(m_out), 128'(3));
    step(0, 1, 8'h22);
    step(0, 1, 8'h0F);
    chk("after_to.valid_out", 128'(valid_out), 128'(1));
    chk("after_to.solution", 128'(solution), 128'hF);
    chk("after_to.n_out", 128'(n_out), 128'(2));
`else
    // Without the timeout, PAYLOAD waits indefinitely
    step(0, 1, 8'h22);
    repeat (50) step(0, 0, 8'h00);
    chk("wait.busy", 128'(busy), 128'(1));
    chk("wait.error", 128'(error), 128'(0));
    step(0, 1, 8'h0F);
    chk("wait.valid_out", 128'(valid_out), 128'(1));
    chk("wait.solution", 128'(solution), 128'hF);
    chk("wait.m_out", 128'(m_out), 128'(2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
    $finish;
  end

endmodule
